apb_cfg_master: RTL and testbench
=================================

// Module: apb_cfg_master
// PURPOSE
//  Single-outstanding APB initiator that programs the AXI node address-map register slave (START/END/VALID/CONNECTIVITY banks).
//  Converts a simple req/gnt + rvalid request port, driven by a boot sequencer or debug bridge, into APB SETUP/ACCESS phases.
//  Honours PREADY wait states and returns PRDATA/PSLVERR to the requester. Sits between the SoC config controller and the node's config APB port.
// PARAMETERS
//  APB_ADDR_WIDTH  12   APB address width (4KB slave window)
//  APB_DATA_WIDTH  32   APB data width
//  TIMEOUT_CYCLES  255  max ACCESS cycles with PREADY low before abort; used only with APB_CFG_TIMEOUT_EN; must be >=1
// PORTS
//  HCLK       in   1               clock, all logic on rising edge
//  HRESETn    in   1               asynchronous active-low reset
//  req_i      in   1               request valid; held with its fields until gnt_o
//  we_i       in   1               1 = write, 0 = read
//  addr_i     in   APB_ADDR_WIDTH  byte address; bits [1:0] ignored
//  wdata_i    in   APB_DATA_WIDTH  write data
//  gnt_o      out  1               request accepted this cycle (req_i && gnt_o)
//  rvalid_o   out  1               one-cycle response pulse, reads and writes
//  rdata_o    out  APB_DATA_WIDTH  read data, valid with rvalid_o (0 for writes)
//  err_o      out  1               PSLVERR or timeout, valid with rvalid_o
//  busy_o     out  1               transfer in SETUP or ACCESS
//  PADDR_o    out  APB_ADDR_WIDTH  APB address, [1:0] forced 0
//  PWDATA_o   out  APB_DATA_WIDTH  APB write data
//  PWRITE_o   out  1               APB direction
//  PSEL_o     out  1               APB select
//  PENABLE_o  out  1               APB enable
//  PRDATA_i   in   APB_DATA_WIDTH  APB read data
//  PREADY_i   in   1               APB ready
//  PSLVERR_i  in   1               APB slave error
// BEHAVIOUR
//  - Reset (async assert, sync deassert via HCLK): state IDLE; all outputs 0; PADDR/PWDATA/PWRITE regs 0.
//  - FSM IDLE -> SETUP -> ACCESS -> (IDLE | SETUP).
//  - IDLE: gnt_o=1. On req_i, register addr/wdata/we into PADDR_o/PWDATA_o/PWRITE_o; next state SETUP.
//  - SETUP: PSEL_o=1, PENABLE_o=0, gnt_o=0; always -> ACCESS next cycle.
//  - ACCESS: PSEL_o=1, PENABLE_o=1; stay while PREADY_i=0. PADDR/PWDATA/PWRITE stable from SETUP to end of ACCESS.
//  - ACCESS with PREADY_i=1 completes: capture rdata (PRDATA_i if read, else 0) and err (PSLVERR_i); rvalid_o=1 next cycle for exactly 1 cycle.
//  - gnt_o = IDLE | (ACCESS & PREADY_i). Grant on the completing cycle goes straight to SETUP, giving back-to-back 2-cycle transfers with PSEL_o held high.
//  - Without a new request on completion, -> IDLE; PSEL_o/PENABLE_o drop. PADDR/PWDATA/PWRITE hold their last value.
//  - Latency req accept -> rvalid_o: 3 cycles with zero wait states, +1 per PREADY-low cycle.
//  - busy_o = (state != IDLE).
//  - Async reset mid-transfer: PSEL/PENABLE drop immediately; no rvalid_o for the killed transfer.
//  - PRDATA_i, PSLVERR_i ignored outside the completing ACCESS cycle.
// CONFIGURATION
//  - APB_CFG_TIMEOUT_EN defined: counter $clog2(TIMEOUT_CYCLES+1) bits.
//    Cleared on entry to ACCESS; +1 per ACCESS cycle with PREADY_i=0.
//    When it reaches TIMEOUT_CYCLES with PREADY_i still 0: abort; rvalid_o next cycle, err_o=1, rdata_o=0, -> IDLE (no grant that cycle).
//  - APB_CFG_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for PREADY_i.
// STRUCTURE
//  - Package apb_cfg_pkg:
//    state enum {IDLE, SETUP, ACCESS};
//    bank selects on PADDR[9:8]: START=2'b00, END=2'b01, VALID=2'b10, CONN=2'b11;
//    entry index field PADDR[7:2]; helper function cfg_addr(bank, idx).
//  - Single module, no sub-modules; timeout counter inline under `ifdef.
// TESTING
//  - Write 0x1C00_0000 to cfg_addr(START,3)=0x00C, PREADY=1: PSEL at T+1, PENABLE at T+2, PADDR=0x00C, PWDATA stable; rvalid at T+3, err=0, rdata=0.
//  - Read 0x104 with PREADY low 4 cycles, PRDATA=0x1C00_FFFF: ACCESS lasts 5 cycles, signals stable; rvalid once, rdata=0x1C00_FFFF.
//  - Three back-to-back writes, req_i held high: PSEL stays 1; PENABLE toggles 0,1,0,1,0,1; 3 rvalid pulses 2 cycles apart.
//  - Read with PSLVERR=1 on completing cycle: err_o=1 with rvalid_o; next transfer reports err_o=0.
//  - HRESETn low during ACCESS: PSEL/PENABLE/gnt 0 immediately; no rvalid; first transfer after release behaves normally.
//  - APB_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY stuck 0: abort after 8 ACCESS cycles; rvalid, err=1, rdata=0; PSEL low next cycle.

Source files
------------

// File: rtl/apb_cfg_pkg.sv
// rtl/apb_cfg_pkg.sv - shared types and address helpers for the APB config master
package apb_cfg_pkg;

  localparam int CFG_ADDR_W = 12;
  localparam int BANK_LSB   = 8;
  localparam int IDX_LSB    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Register bank select carried in PADDR[9:8]
  typedef enum logic [1:0] {
    BANK_START = 2'b00,
    BANK_END   = 2'b01,
    BANK_VALID = 2'b10,
    BANK_CONN  = 2'b11
  } cfg_bank_t;

  // Byte address of entry idx in a bank: {bank, idx, 2'b00}
  function automatic logic [CFG_ADDR_W-1:0] cfg_addr(input cfg_bank_t bank, input logic [5:0] idx);
    cfg_addr = {2'b00, bank, idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - single-outstanding req/gnt to APB initiator (optional ACCESS timeout: APB_CFG_TIMEOUT_EN)
module apb_cfg_master
  import apb_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
  output logic                      PWRITE_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  apb_state_t                r_state;
  apb_state_t                w_state_next;
  logic                      w_gnt;
  logic                      w_done;
  logic                      w_abort;
  logic                      w_timeout;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic                      r_rvalid;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

`ifdef APB_CFG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tcnt;

  // Count PREADY-low ACCESS cycles of the current transfer, restarting in SETUP
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tcnt <= '0;
    end else if (r_state == SETUP) begin
      r_tcnt <= '0;
    end else if (r_state == ACCESS && !PREADY_i) begin
      r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  // The ACCESS cycle that would bring the count to TIMEOUT_CYCLES is the last one
  assign w_timeout = (r_state == ACCESS) && !PREADY_i &&
                     (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, grant, and completion/abort strobes
  always_comb begin
    w_state_next = r_state;
    w_gnt        = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt = 1'b1;
        if (req_i) w_state_next = SETUP;
      end
      SETUP: begin
        w_state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY_i) begin
          w_done       = 1'b1;
          w_gnt        = 1'b1;
          w_state_next = req_i ? SETUP : IDLE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Latch the accepted request onto the APB bus and capture the response
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_gnt && req_i) begin
        r_paddr  <= addr_i & ~APB_ADDR_WIDTH'(3);
        r_pwdata <= wdata_i;
        r_pwrite <= we_i;
      end
      r_rvalid <= w_done | w_abort;
      if (w_done) begin
        r_rdata <= r_pwrite ? '0 : PRDATA_i;
        r_err   <= PSLVERR_i;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  // Grant is forced low while reset is asserted so all outputs read 0
  assign gnt_o     = w_gnt & HRESETn;
  assign PSEL_o    = (r_state != IDLE);
  assign PENABLE_o = (r_state == ACCESS);
  assign busy_o    = (r_state != IDLE);
  assign PADDR_o   = r_paddr;
  assign PWDATA_o  = r_pwdata;
  assign PWRITE_o  = r_pwrite;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - scoreboard bench for apb_cfg_master (timeout case under APB_CFG_TIMEOUT_EN)
module tb_apb_cfg_master;
  import apb_cfg_pkg::*;

  localparam int TB_TIMEOUT = 8;

  logic        HCLK;
  logic        HRESETn;
  logic        req_i;
  logic        we_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        busy_o;
  logic [11:0] PADDR_o;
  logic [31:0] PWDATA_o;
  logic        PWRITE_o;
  logic        PSEL_o;
  logic        PENABLE_o;
  logic [31:0] PRDATA_i;
  logic        PREADY_i;
  logic        PSLVERR_i;

  apb_cfg_master #(
    .APB_ADDR_WIDTH(12),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .busy_o   (busy_o),
    .PADDR_o  (PADDR_o),
    .PWDATA_o (PWDATA_o),
    .PWRITE_o (PWRITE_o),
    .PSEL_o   (PSEL_o),
    .PENABLE_o(PENABLE_o),
    .PRDATA_i (PRDATA_i),
    .PREADY_i (PREADY_i),
    .PSLVERR_i(PSLVERR_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
    logic        w;
  } apb_t;

  exp_t     exp_q[$];
  apb_t     apb_q[$];
  int       s_wait_q[$];
  bit [31:0] model_mem[256];
  bit [31:0] slv_mem[256];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit addr_err(input logic [11:0] a);
    return a[7:2] == 6'h3F;
  endfunction

  // Issue one request; returns at posedge+1 of the accepting edge
  task automatic do_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        input int wt, input bit abort);
    exp_t e;
    apb_t p;
    bit   ok;
    ok      = 0;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    for (int c = 0; c < 300; c++) begin
      @(negedge HCLK);
      if (gnt_o) begin
        ok = 1;
        break;
      end
      @(posedge HCLK);
      #1;
    end
    if (!ok) begin
      chk("gnt_timeout", 32'd0, 32'd1);
    end else begin
      if (abort) begin
        e.rdata = 32'd0;
        e.err   = 1'b1;
        e.cyc   = cyc + 3 + (TB_TIMEOUT - 1);
        s_wait_q.push_back(1000);
      end else begin
        e.err = addr_err(addr);
        e.cyc = cyc + 3 + wt;
        if (we) begin
          e.rdata = 32'd0;
          if (!e.err) model_mem[addr[9:2]] = wdata;
        end else begin
          e.rdata = model_mem[addr[9:2]];
        end
        p.a = addr & ~12'h3;
        p.d = wdata;
        p.w = we;
        apb_q.push_back(p);
        s_wait_q.push_back(wt);
      end
      exp_q.push_back(e);
      @(posedge HCLK);
      #1;
    end
    req_i = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge HCLK);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // APB slave: programmable wait states, garbage on non-completing cycles
  int          s_wait_left;
  bit          s_in_acc;
  bit          s_stable;
  logic [11:0] s_a;
  logic [31:0] s_d;
  logic        s_w;
  apb_t        s_p;

  initial begin
    PREADY_i  = 1'b0;
    PRDATA_i  = 32'd0;
    PSLVERR_i = 1'b0;
    s_in_acc  = 0;
    forever begin
      @(posedge HCLK);
      #2;
      if (!HRESETn) begin
        s_in_acc = 0;
        PREADY_i = 1'b0;
        continue;
      end
      PRDATA_i  = $urandom;
      PSLVERR_i = 1'($urandom_range(0, 1));
      PREADY_i  = 1'($urandom_range(0, 1));
      if (PSEL_o && !PENABLE_o) begin
        s_a      = PADDR_o;
        s_d      = PWDATA_o;
        s_w      = PWRITE_o;
        s_in_acc = 0;
      end else if (PSEL_o && PENABLE_o) begin
        if (!s_in_acc) begin
          s_in_acc    = 1;
          s_stable    = 1;
          s_wait_left = (s_wait_q.size() != 0) ? s_wait_q.pop_front() : 0;
        end
        if (PADDR_o !== s_a || PWDATA_o !== s_d || PWRITE_o !== s_w) s_stable = 0;
        if (s_wait_left == 0) begin
          PREADY_i  = 1'b1;
          PSLVERR_i = addr_err(PADDR_o);
          if (!s_w) PRDATA_i = slv_mem[PADDR_o[9:2]];
          else if (!PSLVERR_i) slv_mem[PADDR_o[9:2]] = s_d;
          s_in_acc = 0;
          chk("apb_stable", 32'(s_stable), 32'd1);
          if (apb_q.size() == 0) begin
            chk("apb_unexpected", 32'd1, 32'd0);
          end else begin
            s_p = apb_q.pop_front();
            chk("apb_paddr", 32'(s_a), 32'(s_p.a));
            chk("apb_pwdata", s_d, s_p.d);
            chk("apb_pwrite", 32'(s_w), 32'(s_p.w));
          end
        end else begin
          PREADY_i = 1'b0;
          s_wait_left--;
        end
      end else begin
        s_in_acc = 0;
      end
    end
  end

  // Response monitor
  exp_t m_e;
  initial begin
    forever begin
      @(negedge HCLK);
      if (HRESETn && rvalid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          chk("rdata", rdata_o, m_e.rdata);
          chk("err", 32'(err_o), 32'(m_e.err));
          chk("latency", 32'(cyc), 32'(m_e.cyc));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [5:0]  bb_psel;
  logic [5:0]  bb_pen;
  logic [11:0] r_addr;

  initial begin
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_ctrl", {gnt_o, rvalid_o, busy_o, PSEL_o, PENABLE_o, PWRITE_o, err_o}, 0);
    chk("reset_paddr", 32'(PADDR_o), 0);
    chk("reset_pwdata", PWDATA_o, 0);
    chk("reset_rdata", rdata_o, 0);
    HRESETn = 1'b1;
    #1;
    chk("idle_gnt_busy", {gnt_o, busy_o}, 2'b10);
    @(posedge HCLK);
    #1;

    // First write: SETUP at T+1, ACCESS at T+2, rvalid at T+3 (monitor latency)
    do_req(1'b1, cfg_addr(BANK_START, 6'd3), 32'h1C00_0000, 0, 0);
    chk("setup_phase", {PSEL_o, PENABLE_o, busy_o, gnt_o}, 4'b1010);
    chk("setup_paddr", 32'(PADDR_o), 32'h00C);
    chk("setup_pwdata", PWDATA_o, 32'h1C00_0000);
    chk("setup_pwrite", 32'(PWRITE_o), 1);
    @(posedge HCLK);
    #1;
    chk("access_phase", {PSEL_o, PENABLE_o}, 2'b11);
    drain();

    // Read with four wait states
    do_req(1'b1, 12'h104, 32'h1C00_FFFF, 0, 0);
    do_req(1'b0, 12'h104, 32'hDEAD_BEEF, 4, 0);
    drain();

    // Three back-to-back writes with req held
    fork
      begin
        do_req(1'b1, cfg_addr(BANK_END, 6'd0), 32'h0000_0011, 0, 0);
        do_req(1'b1, cfg_addr(BANK_END, 6'd1), 32'h0000_0022, 0, 0);
        do_req(1'b1, cfg_addr(BANK_END, 6'd2), 32'h0000_0033, 0, 0);
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge HCLK);
          if (PSEL_o) break;
        end
        for (int i = 0; i < 6; i++) begin
          if (i != 0) @(negedge HCLK);
          bb_psel[i] = PSEL_o;
          bb_pen[i]  = PENABLE_o;
        end
        chk("b2b_psel", 32'(bb_psel), 32'h3F);
        chk("b2b_penable", 32'(bb_pen), 32'h2A);
      end
    join
    drain();

    // Slave error then a clean transfer
    do_req(1'b0, cfg_addr(BANK_VALID, 6'd63), 32'd0, 1, 0);
    do_req(1'b1, cfg_addr(BANK_VALID, 6'd2), 32'hA5A5_0001, 0, 0);
    drain();

    // Reset in the middle of ACCESS kills the transfer
    do_req(1'b0, 12'h104, 32'd0, 6, 0);
    @(posedge HCLK);
    #1;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    exp_q.delete();
    apb_q.delete();
    s_wait_q.delete();
    #1;
    chk("kill_outs", {PSEL_o, PENABLE_o, gnt_o, busy_o}, 4'b0000);
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    do_req(1'b0, 12'h104, 32'd0, 0, 0);
    drain();

`ifdef APB_CFG_TIMEOUT_EN
    do_req(1'b0, cfg_addr(BANK_CONN, 6'd5), 32'd0, 0, 1);
    drain();
    chk("timeout_psel_low", {PSEL_o, PENABLE_o}, 2'b00);
`endif

    // Randomized traffic over a small address set so reads hit earlier writes
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge HCLK);
        #1;
      end
      r_addr = cfg_addr(cfg_bank_t'($urandom_range(0, 1)), 6'($urandom_range(60, 63)))
               | 12'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), r_addr, $urandom, $urandom_range(0, 3), 0);
    end
    drain();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
